pc_fetch_unit: RTL and testbench

Program-counter and fetch-control stage that sits directly upstream of the instruction memory. It drives the byte address `pc` into the memory and receives `inst_in` from it one clock later. It pairs each returned word with the PC that fetched it, and applies stalls and branch/jump redirects. Wrong-path words are squashed, and a clean `inst_out`/`inst_pc`/`inst_valid` triple is handed to decode.

---
 rtl/mips_pkg.sv | 6 +
 rtl/fetch_hold_buffer.sv | 21 ++
 rtl/pc_fetch_unit.sv | 83 ++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants and fetch FSM encoding shared by the fetch stage.
package mips_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} fsm_t;
endpackage

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: single-entry skid register keeping the decode word alive across a stall.
module fetch_hold_buffer
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        capture,
  input  logic        release_en,
  input  logic        clear,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        valid
);
  always_ff @(posedge clock)
    if (clear || release_en) begin
      data <= NOP;
      valid <= 1'b0;
    end else if (capture) begin
      data <= word;
      valid <= 1'b1;
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencing, stall hold and one-bubble redirect squash ahead of instruction memory.
// Define PC_ALIGN_CHECK_EN to report misaligned redirect targets on a sticky misalign_err.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        misalign_err
);
  localparam logic [31:0] IMEM_BYTES = IMEM_WORDS * WORD_BYTES;
  fsm_t fsm;
  logic [31:0] seq_pc, raw_target, target, hold_inst;
  logic redirect, hold_valid;
  always_comb begin
    seq_pc = (pc + WORD_BYTES) % IMEM_BYTES;
    raw_target = jump ? {4'((inst_pc + WORD_BYTES) >> 28), jump_index, 2'b00} : branch_target;
    target = raw_target & ~32'd3;
    redirect = jump | branch_taken;
  end
  // HOLD release behaves like an unstalled RUN edge, so a held redirect is taken then.
  always_ff @(posedge clock)
    if (!reset_n) begin
      fsm <= BOOT;
      pc <= RESET_PC;
      inst_pc <= '0;
      inst_valid <= 1'b0;
    end else begin
      case (fsm)
        BOOT: begin
          fsm <= RUN;
          pc <= seq_pc;
          inst_pc <= pc;
          inst_valid <= 1'b1;
        end
        RUN, HOLD:
          if (stall) fsm <= HOLD;
          else begin
            fsm <= redirect ? FLUSH : RUN;
            pc <= redirect ? target : seq_pc;
            inst_pc <= pc;
            inst_valid <= !redirect;
          end
        FLUSH:
          if (!stall) begin
            fsm <= RUN;
            pc <= seq_pc;
            inst_pc <= pc;
            inst_valid <= 1'b1;
          end
        default: fsm <= BOOT;
      endcase
    end
`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clock)
    if (!reset_n) misalign_err <= 1'b0;
    else if ((fsm == RUN || fsm == HOLD) && !stall && redirect && raw_target[1:0] != 2'b00) misalign_err <= 1'b1;
`else
  assign misalign_err = 1'b0;
`endif
  fetch_hold_buffer u_hold (
    .clock(clock),
    .capture(fsm == RUN && stall),
    .release_en(fsm == HOLD && !stall),
    .clear(!reset_n),
    .word(inst_in),
    .data(hold_inst),
    .valid(hold_valid)
  );
  assign inst_out = !inst_valid ? NOP : hold_valid ? hold_inst : inst_in;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus against a fetch-stream model plus literal spot checks.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] IMEM_BYTES = 32'd128;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif
  logic clock = 1'b0;
  logic reset_n, stall, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] pc, inst_in, inst_out, inst_pc;
  logic inst_valid, misalign_err;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc, m_ipc;
  logic m_valid, m_err, m_boot;
  logic m_known = 1'b0;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(32)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .pc(pc), .inst_in(inst_in),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return 32'hC0DE_0000 | (a % IMEM_BYTES);
  endfunction

  // Instruction memory: one-cycle read of the address presented on pc.
  always @(posedge clock) inst_in <= word_at(pc);

  function automatic logic [31:0] raw_target(logic [31:0] ipc);
    logic [31:0] lp;
    lp = ipc + 32'd4;
    return jump ? {lp[31:28], jump_index, 2'b00} : branch_target;
  endfunction

  // Decode holds (m_valid, m_ipc); a redirect is taken only when a real instruction is unstalled.
  always @(posedge clock)
    if (!reset_n) begin
      m_pc <= RESET_PC;
      m_ipc <= 32'h0;
      m_valid <= 1'b0;
      m_err <= 1'b0;
      m_boot <= 1'b1;
      m_known <= 1'b1;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      m_ipc <= m_pc;
      m_pc <= (m_pc + 32'd4) % IMEM_BYTES;
      m_valid <= 1'b1;
    end else if (!stall) begin
      m_ipc <= m_pc;
      if (m_valid && (jump || branch_taken)) begin
        m_pc <= raw_target(m_ipc) & ~32'd3;
        m_valid <= 1'b0;
        if (ERR_EXP != 0 && (raw_target(m_ipc) & 32'd3) != 0) m_err <= 1'b1;
      end else begin
        m_pc <= (m_pc + 32'd4) % IMEM_BYTES;
        m_valid <= 1'b1;
      end
    end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock)
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("inst_pc", inst_pc, m_ipc);
      chk("inst_valid", inst_valid, m_valid);
      chk("inst_out", inst_out, m_valid ? word_at(m_ipc) : 32'h0);
      chk("misalign_err", misalign_err, m_err);
    end

  task automatic adv(int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    branch_target = 32'h0;
    jump_index = 26'h0;
    inst_in = 32'h0;
    adv(3);
    chk("lit_rst_pc", pc, 32'h0);
    chk("lit_rst_valid", inst_valid, 32'h0);
    chk("lit_rst_out", inst_out, 32'h0);
    chk("lit_rst_ipc", inst_pc, 32'h0);
    reset_n = 1'b1;
    adv(1);
    chk("lit_first_pc", pc, 32'd4);
    chk("lit_first_valid", inst_valid, 32'd1);
    chk("lit_first_out", inst_out, 32'hC0DE_0000);
    adv(3);
    chk("lit_pre_stall_ipc", inst_pc, 32'd12);
    stall = 1'b1;
    adv(3);
    chk("lit_stall_pc", pc, 32'd16);
    chk("lit_stall_ipc", inst_pc, 32'd12);
    chk("lit_stall_out", inst_out, 32'hC0DE_000C);
    stall = 1'b0;
    adv(1);
    chk("lit_release_ipc", inst_pc, 32'd16);
    chk("lit_release_out", inst_out, 32'hC0DE_0010);
    adv(1);
    jump = 1'b1;
    jump_index = 26'd5;
    adv(1);
    chk("lit_jump_pc", pc, 32'd20);
    chk("lit_jump_bubble", inst_valid, 32'd0);
    jump = 1'b0;
    adv(1);
    chk("lit_jump_ipc", inst_pc, 32'd20);
    adv(1);
    jump = 1'b1;
    jump_index = 26'd1;
    branch_taken = 1'b1;
    branch_target = 32'd100;
    adv(1);
    chk("lit_jump_wins", pc, 32'd4);
    jump = 1'b0;
    branch_taken = 1'b0;
    adv(2);
    chk("lit_pre_branch_ipc", inst_pc, 32'd8);
    branch_taken = 1'b1;
    branch_target = 32'd40;
    adv(1);
    chk("lit_branch_pc", pc, 32'd40);
    chk("lit_branch_out", inst_out, 32'h0);
    branch_taken = 1'b0;
    adv(1);
    chk("lit_branch_ipc", inst_pc, 32'd40);
    chk("lit_branch_out2", inst_out, 32'hC0DE_0028);
    branch_taken = 1'b1;
    branch_target = 32'd120;
    adv(1);
    branch_taken = 1'b0;
    stall = 1'b1;
    adv(2);
    chk("lit_flush_stall_valid", inst_valid, 32'd0);
    chk("lit_flush_stall_pc", pc, 32'd120);
    stall = 1'b0;
    adv(2);
    chk("lit_wrap_pc", pc, 32'd0);
    chk("lit_wrap_ipc", inst_pc, 32'd124);
    adv(1);
    chk("lit_wrap_valid", inst_valid, 32'd1);
    branch_taken = 1'b1;
    branch_target = 32'd42;
    adv(1);
    chk("lit_misalign_pc", pc, 32'd40);
    chk("lit_misalign_err", misalign_err, ERR_EXP);
    branch_taken = 1'b0;
    adv(1);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'd60;
    adv(2);
    chk("lit_redirect_ignored", pc, 32'd44);
    chk("lit_sticky_err", misalign_err, ERR_EXP);
    stall = 1'b0;
    adv(1);
    chk("lit_held_redirect", pc, 32'd60);
    branch_taken = 1'b0;
    adv(1);
    stall = 1'b1;
    adv(1);
    reset_n = 1'b0;
    adv(1);
    chk("lit_hold_rst_pc", pc, 32'h0);
    chk("lit_hold_rst_valid", inst_valid, 32'd0);
    chk("lit_hold_rst_err", misalign_err, 32'd0);
    stall = 1'b0;
    reset_n = 1'b1;
    adv(1);
    chk("lit_reboot_pc", pc, 32'd4);
    adv(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
